reset_seq: RTL

RESET_SEQ -- requirements
Module: reset_seq

---
 rtl/reset_seq_pkg.sv | 14 +
 rtl/sync_2ff.sv | 21 ++
 rtl/reset_seq.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/reset_seq_pkg.sv
// rtl/reset_seq_pkg.sv - shared FSM state type and counter widths for the reset sequencer
package reset_seq_pkg;

    localparam int CNT_W = 16;
    localparam int IDX_W = 3;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        RELEASE   = 2'd1,
        RUN       = 2'd2,
        SOFT_HOLD = 2'd3
    } state_t;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop single-bit synchronizer, clears to 0 on reset
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/reset_seq.sv
// rtl/reset_seq.sv - staged reset release sequencer gated on PLL lock with soft reset
// Optional watchdog: define RESET_SEQ_WDT_EN.
module reset_seq
    import reset_seq_pkg::*;
#(
    parameter int NUM_STAGES      = 4,
    parameter int STAGE_DLY       = 1024,
    parameter int SOFT_RST_CYCLES = 16
`ifdef RESET_SEQ_WDT_EN
    ,
    parameter int WDT_TIMEOUT     = 1000000
`endif
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  pll_locked,
    input  logic                  soft_rst_req,
`ifdef RESET_SEQ_WDT_EN
    input  logic                  wdt_kick,
    output logic                  wdt_fired,
`endif
    output logic [NUM_STAGES-1:0] stage_rst_n,
    output logic                  all_ready,
    output logic                  busy
);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    logic             lock;
    logic             soft_trig;

    sync_2ff u_lock_sync (
        .clk   (clk),
        .rst_n (reset_n),
        .d     (pll_locked),
        .q     (lock)
    );

`ifdef RESET_SEQ_WDT_EN
    localparam int WDT_W = $clog2(WDT_TIMEOUT + 1);

    logic [WDT_W-1:0] wdt_cnt;
    logic             wdt_expire;

    // Fires on the edge the count would reach WDT_TIMEOUT; a kick on that edge still saves it.
    assign wdt_expire = (state == RUN) && !wdt_kick && (wdt_cnt == WDT_W'(WDT_TIMEOUT - 1));
    assign soft_trig  = soft_rst_req || wdt_expire;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wdt_cnt   <= '0;
            wdt_fired <= 1'b0;
        end else begin
            if (state != RUN || wdt_kick)
                wdt_cnt <= '0;
            else
                wdt_cnt <= wdt_cnt + 1'b1;
            if (wdt_expire)
                wdt_fired <= 1'b1;
        end
    end
`else
    assign soft_trig = soft_rst_req;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= WAIT_LOCK;
            cnt         <= '0;
            idx         <= '0;
            stage_rst_n <= '0;
            all_ready   <= 1'b0;
            busy        <= 1'b1;
        end else begin
            case (state)
                WAIT_LOCK: begin
                    stage_rst_n <= '0;
                    all_ready   <= 1'b0;
                    busy        <= 1'b1;
                    if (lock) begin
                        state <= RELEASE;
                        cnt   <= CNT_W'(STAGE_DLY - 1);
                        idx   <= '0;
                    end
                end
                RELEASE: begin
                    if (!lock) begin
                        state       <= WAIT_LOCK;
                        cnt         <= '0;
                        stage_rst_n <= '0;
                        all_ready   <= 1'b0;
                        busy        <= 1'b1;
                    end else if (cnt == '0) begin
                        // Stages release strictly upward, so shifting in a 1 releases stage idx.
                        stage_rst_n <= {stage_rst_n[NUM_STAGES-2:0], 1'b1};
                        cnt         <= CNT_W'(STAGE_DLY - 1);
                        if (idx == IDX_W'(NUM_STAGES - 1)) begin
                            state     <= RUN;
                            all_ready <= 1'b1;
                            busy      <= 1'b0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RUN: begin
                    if (!lock) begin
                        state       <= WAIT_LOCK;
                        cnt         <= '0;
                        stage_rst_n <= '0;
                        all_ready   <= 1'b0;
                        busy        <= 1'b1;
                    end else if (soft_trig) begin
                        state       <= SOFT_HOLD;
                        cnt         <= CNT_W'(SOFT_RST_CYCLES - 1);
                        stage_rst_n <= '0;
                        all_ready   <= 1'b0;
                        busy        <= 1'b1;
                    end
                end
                SOFT_HOLD: begin
                    stage_rst_n <= '0;
                    all_ready   <= 1'b0;
                    busy        <= 1'b1;
                    if (!lock) begin
                        state <= WAIT_LOCK;
                        cnt   <= '0;
                    end else if (cnt == '0) begin
                        state <= WAIT_LOCK;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state       <= WAIT_LOCK;
                    cnt         <= '0;
                    stage_rst_n <= '0;
                    all_ready   <= 1'b0;
                    busy        <= 1'b1;
                end
            endcase
        end
    end

endmodule
